seq_timer_dev: RTL and testbench

//  Countdown timer device on one of the eight sequencer output slots. Consumes the sequencer's

---
 rtl/seq_timer_dev_pkg.sv | 64 ++++++
 rtl/seq_timer_dev_prescaler.sv | 39 +++
 rtl/seq_timer_dev.sv | 179 +++++++++++++++++
 tb/tb_seq_timer_dev.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_timer_dev_pkg.sv
// Shared definitions for the sequencer countdown-timer device.
// Holds widths, the command word layout, opcode and readback-select
// encodings, the control state encoding and debug name decoders.
package seq_timer_dev_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CMD_W  = OP_W + DATA_W;
    localparam int unsigned SEL_W  = 2;

    // Command word as presented on the sequencer output register
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] arg;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDP   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LDC   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_START = OP_W'(3);
    localparam logic [OP_W-1:0] OP_STOP  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_CLR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SEL   = OP_W'(6);

    localparam logic [SEL_W-1:0] SEL_COUNT    = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_PRESCALE = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_FLAGS    = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_RELOAD   = SEL_W'(3);

    // Five-character ASCII names for waveform viewing
    function automatic logic [39:0] state_name(input state_e s);
        logic [39:0] n;
        case (s)
            ST_RESET: n = "RESET";
            ST_IDLE:  n = "IDLE ";
            ST_RUN:   n = "RUN  ";
            default:  n = "ERROR";
        endcase
        return n;
    endfunction

    function automatic logic [39:0] op_name(input logic [OP_W-1:0] op);
        logic [39:0] n;
        case (op)
            OP_NOP:   n = "NOP  ";
            OP_LDP:   n = "LDP  ";
            OP_LDC:   n = "LDC  ";
            OP_START: n = "START";
            OP_STOP:  n = "STOP ";
            OP_CLR:   n = "CLR  ";
            OP_SEL:   n = "SEL  ";
            default:  n = "ILLEG";
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_timer_dev_prescaler.sv
// 8-bit prescaler down-counter for the timer device.
// Ports: clock/reset (sync, active-high); load/load_val overwrite the
// counter; run lets it count down; tick (combinational) is high while
// running with the counter at zero. The owner reloads on tick via load.
module seq_timer_dev_prescaler
    import seq_timer_dev_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              run,
    output logic              tick
);

    logic [DATA_W-1:0] pcnt_q;
    logic [DATA_W-1:0] pcnt_d;

    assign tick = run && (pcnt_q == '0);

    // Load has priority; otherwise count down and park at zero
    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = load_val;
        end else if (run && (pcnt_q != '0)) begin
            pcnt_d = pcnt_q - DATA_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/seq_timer_dev.sv
// Countdown timer device on a sequencer output slot.
// Ports: clock, reset (sync, active-high); cmd {op,arg} qualified by
// cmd_wen; rdata registered readback selected by SEL; expired sticky
// expiry flag; error high while the device sits in Error.
module seq_timer_dev
    import seq_timer_dev_pkg::*;
#(
    parameter bit RELOAD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_wen,
    output logic [DATA_W-1:0] rdata,
    output logic              expired,
    output logic              error
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] reload_q, reload_d;
    logic [DATA_W-1:0] prescale_q, prescale_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              expired_q, expired_d;
    logic              error_q, error_d;

    logic              pre_load;
    logic [DATA_W-1:0] pre_load_val;
    logic              pre_run;
    logic              tick;

    cmd_t cmd_s;
    logic cmd_act;
    logic is_ldp, is_ldc, is_start, is_stop, is_clr, is_sel, is_ill;
    logic expire_c;

    logic [39:0] dbg_state_unused;
    logic [39:0] dbg_op_unused;

    // Command decode: only acted on in Idle/Run with the write enable high
    assign cmd_s    = cmd;
    assign cmd_act  = cmd_wen && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign is_ldp   = cmd_act && (cmd_s.op == OP_LDP);
    assign is_ldc   = cmd_act && (cmd_s.op == OP_LDC);
    assign is_start = cmd_act && (cmd_s.op == OP_START);
    assign is_stop  = cmd_act && (cmd_s.op == OP_STOP);
    assign is_clr   = cmd_act && (cmd_s.op == OP_CLR);
    assign is_sel   = cmd_act && (cmd_s.op == OP_SEL);
    assign is_ill   = cmd_act && (cmd_s.op > OP_SEL);
    assign expire_c = tick && (count_q == '0);

    // START restarts the phase and STOP freezes it, so both mask the tick
    assign pre_run = (state_q == ST_RUN) && !is_start && !is_stop;

    seq_timer_dev_prescaler u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .load     (pre_load),
        .load_val (pre_load_val),
        .run      (pre_run),
        .tick     (tick)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (is_ill)        state_d = ST_ERROR;
                else if (is_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (is_ill)                      state_d = ST_ERROR;
                else if (is_stop)                state_d = ST_IDLE;
                else if (expire_c && !RELOAD_EN) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // Datapath / output logic; later assignments carry the priority
    always_comb begin
        count_d      = count_q;
        reload_d     = reload_q;
        prescale_d   = prescale_q;
        sel_d        = sel_q;
        expired_d    = expired_q;
        error_d      = 1'b0;
        pre_load     = 1'b0;
        pre_load_val = prescale_q;

        if (is_clr) expired_d = 1'b0;

        if (tick) begin
            pre_load = 1'b1;
            if (count_q != '0) begin
                count_d = count_q - DATA_W'(1);
            end else begin
                expired_d = 1'b1;
                if (RELOAD_EN) count_d = reload_q;
            end
        end

        if (is_ldp) begin
            prescale_d   = cmd_s.arg;
            pre_load     = 1'b1;
            pre_load_val = cmd_s.arg;
        end
        if (is_ldc) begin
            count_d  = cmd_s.arg;
            reload_d = cmd_s.arg;
        end
        if (is_start) pre_load = 1'b1;
        if (is_sel)   sel_d    = cmd_s.arg[SEL_W-1:0];

        case (sel_q)
            SEL_COUNT:    rdata_d = count_q;
            SEL_PRESCALE: rdata_d = prescale_q;
            SEL_FLAGS:    rdata_d = DATA_W'({error_q, expired_q});
            SEL_RELOAD:   rdata_d = reload_q;
            default:      rdata_d = '0;
        endcase

        // Error clears everything from the entry edge onward
        if (state_d == ST_ERROR) begin
            count_d      = '0;
            reload_d     = '0;
            prescale_d   = '0;
            expired_d    = 1'b0;
            rdata_d      = '0;
            error_d      = 1'b1;
            pre_load     = 1'b1;
            pre_load_val = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
            expired_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            sel_q      <= sel_d;
            rdata_q    <= rdata_d;
            expired_q  <= expired_d;
            error_q    <= error_d;
        end
    end

    assign rdata   = rdata_q;
    assign expired = expired_q;
    assign error   = error_q;

    // Debug names for waveform viewing
    always_comb begin
        dbg_state_unused = state_name(state_q);
        dbg_op_unused    = op_name(cmd_s.op);
    end

endmodule

// File: tb/tb_seq_timer_dev.sv
// Directed bench for seq_timer_dev: one-shot (RELOAD_EN=0) and reloading
// (RELOAD_EN=1) instances share the same command stream.
module tb_seq_timer_dev;

    localparam logic [3:0] OP_LDP   = 4'd1;
    localparam logic [3:0] OP_LDC   = 4'd2;
    localparam logic [3:0] OP_START = 4'd3;
    localparam logic [3:0] OP_STOP  = 4'd4;
    localparam logic [3:0] OP_CLR   = 4'd5;
    localparam logic [3:0] OP_SEL   = 4'd6;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] cmd;
    logic        cmd_wen;
    logic [7:0]  rdata0, rdata1;
    logic        expired0, expired1, error0, error1;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_timer_dev #(.RELOAD_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_wen(cmd_wen),
        .rdata(rdata0), .expired(expired0), .error(error0)
    );

    seq_timer_dev #(.RELOAD_EN(1'b1)) dut1 (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_wen(cmd_wen),
        .rdata(rdata1), .expired(expired1), .error(error1)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] arg);
        cmd     = {op, arg};
        cmd_wen = 1'b1;
        step(1);
        cmd_wen = 1'b0;
        cmd     = '0;
    endtask

    // Leaves the devices in Idle, ready to accept a command on the next edge
    task automatic do_reset;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd = '0; cmd_wen = 1'b0;
        step(2);
        checks++; if ({rdata0, rdata1} !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", {rdata0, rdata1}); end
        checks++; if ({expired0, expired1, error0, error1} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {expired0, expired1, error0, error1}); end
        reset = 1'b0;
        step(3);
        checks++; if ({rdata0, rdata1, expired0, expired1, error0, error1} !== 20'h0) begin failures++; $display("FAIL post_reset_idle got=%h exp=0", {rdata0, rdata1, expired0, expired1, error0, error1}); end
    endtask

    // Prescale 0, count 3: count 3,2,1,0 then expiry on the 4th tick
    task automatic test_single_shot;
        logic [7:0] exp0 [5];
        logic [7:0] exp1 [5];
        logic       expd [5];
        exp0 = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        exp1 = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        expd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset;
        issue(OP_LDP, 8'd0);
        issue(OP_LDC, 8'd3);
        issue(OP_START, 8'd0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            checks++; if (rdata0 !== exp0[k]) begin failures++; $display("FAIL t1_rdata0[%0d] got=%0d exp=%0d", k, rdata0, exp0[k]); end
            checks++; if (rdata1 !== exp1[k]) begin failures++; $display("FAIL t1_rdata1[%0d] got=%0d exp=%0d", k, rdata1, exp1[k]); end
            checks++; if (expired0 !== expd[k]) begin failures++; $display("FAIL t1_expired0[%0d] got=%b exp=%b", k, expired0, expd[k]); end
            checks++; if (expired1 !== expd[k]) begin failures++; $display("FAIL t1_expired1[%0d] got=%b exp=%b", k, expired1, expd[k]); end
        end
        // One-shot instance is Idle: after CLR it must not expire again
        issue(OP_CLR, 8'd0);
        step(3);
        checks++; if (expired0 !== 1'b0) begin failures++; $display("FAIL t1_idle_after_expiry got=%b exp=0", expired0); end
        checks++; if (expired1 !== 1'b1) begin failures++; $display("FAIL t1_reload_reexpire got=%b exp=1", expired1); end
    endtask

    // Prescale 4, count 1: ticks 5 edges apart
    task automatic test_prescale;
        do_reset;
        issue(OP_LDP, 8'd4);
        issue(OP_LDC, 8'd1);
        issue(OP_START, 8'd0);
        step(5);
        checks++; if ({rdata0, rdata1} !== {8'd1, 8'd1}) begin failures++; $display("FAIL t2_before_tick got=%h exp=0101", {rdata0, rdata1}); end
        step(1);
        checks++; if ({rdata0, rdata1} !== {8'd0, 8'd0}) begin failures++; $display("FAIL t2_first_dec got=%h exp=0000", {rdata0, rdata1}); end
        step(3);
        checks++; if ({expired0, expired1} !== 2'b00) begin failures++; $display("FAIL t2_early_expiry got=%b exp=00", {expired0, expired1}); end
        step(1);
        checks++; if ({expired0, expired1} !== 2'b11) begin failures++; $display("FAIL t2_expiry got=%b exp=11", {expired0, expired1}); end
        step(1);
        checks++; if ({rdata0, rdata1} !== {8'd0, 8'd1}) begin failures++; $display("FAIL t2_reload got=%h exp=0001", {rdata0, rdata1}); end
    endtask

    // Reload mode wrap, CLR, and CLR coincident with an expiring tick
    task automatic test_reload;
        logic [7:0] exp1 [4];
        logic       expd [4];
        exp1 = '{8'd2, 8'd1, 8'd0, 8'd2};
        expd = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset;
        issue(OP_LDP, 8'd0);
        issue(OP_LDC, 8'd2);
        issue(OP_START, 8'd0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            checks++; if (rdata1 !== exp1[k]) begin failures++; $display("FAIL t3_rdata1[%0d] got=%0d exp=%0d", k, rdata1, exp1[k]); end
            checks++; if (expired1 !== expd[k]) begin failures++; $display("FAIL t3_expired1[%0d] got=%b exp=%b", k, expired1, expd[k]); end
        end
        issue(OP_CLR, 8'd0);
        checks++; if (expired1 !== 1'b0) begin failures++; $display("FAIL t3_clr got=%b exp=0", expired1); end
        step(1);
        checks++; if (expired1 !== 1'b1) begin failures++; $display("FAIL t3_reexpire got=%b exp=1", expired1); end
        step(2);
        issue(OP_CLR, 8'd0);
        checks++; if (expired1 !== 1'b1) begin failures++; $display("FAIL t3_clr_vs_set got=%b exp=1", expired1); end
        checks++; if (expired0 !== 1'b0) begin failures++; $display("FAIL t3_oneshot_cleared got=%b exp=0", expired0); end
        checks++; if (rdata1 !== 8'd0) begin failures++; $display("FAIL t3_count_at_clr got=%0d exp=0", rdata1); end
        step(1);
        checks++; if (rdata1 !== 8'd2) begin failures++; $display("FAIL t3_wrap2 got=%0d exp=2", rdata1); end
    endtask

    // STOP coincident with a tick freezes the count; START resumes
    task automatic test_stop;
        do_reset;
        issue(OP_LDP, 8'd0);
        issue(OP_LDC, 8'd5);
        issue(OP_START, 8'd0);
        issue(OP_STOP, 8'd0);
        step(2);
        checks++; if ({rdata0, rdata1} !== {8'd5, 8'd5}) begin failures++; $display("FAIL t4_stopped got=%h exp=0505", {rdata0, rdata1}); end
        checks++; if ({expired0, expired1} !== 2'b00) begin failures++; $display("FAIL t4_no_expiry got=%b exp=00", {expired0, expired1}); end
        issue(OP_START, 8'd0);
        step(1);
        checks++; if ({rdata0, rdata1} !== {8'd5, 8'd5}) begin failures++; $display("FAIL t4_restart got=%h exp=0505", {rdata0, rdata1}); end
        step(1);
        checks++; if ({rdata0, rdata1} !== {8'd4, 8'd4}) begin failures++; $display("FAIL t4_resume_tick got=%h exp=0404", {rdata0, rdata1}); end
    endtask

    // Illegal opcode: ignored without write enable, sticky Error with it
    task automatic test_error;
        do_reset;
        issue(OP_LDC, 8'd7);
        cmd = {4'd9, 8'h00}; cmd_wen = 1'b0;
        step(1);
        cmd = '0;
        checks++; if ({error0, error1} !== 2'b00) begin failures++; $display("FAIL t5_wen_low_err got=%b exp=00", {error0, error1}); end
        checks++; if ({rdata0, rdata1} !== {8'd7, 8'd7}) begin failures++; $display("FAIL t5_wen_low_rdata got=%h exp=0707", {rdata0, rdata1}); end
        issue(4'd9, 8'h55);
        checks++; if ({error0, error1} !== 2'b11) begin failures++; $display("FAIL t5_error_entry got=%b exp=11", {error0, error1}); end
        checks++; if ({rdata0, rdata1} !== 16'h0000) begin failures++; $display("FAIL t5_entry_rdata got=%h exp=0000", {rdata0, rdata1}); end
        issue(OP_LDC, 8'h22);
        issue(OP_START, 8'd0);
        issue(OP_SEL, 8'd2);
        step(2);
        checks++; if ({error0, error1, expired0, expired1} !== 4'b1100) begin failures++; $display("FAIL t5_sticky got=%b exp=1100", {error0, error1, expired0, expired1}); end
        checks++; if ({rdata0, rdata1} !== 16'h0000) begin failures++; $display("FAIL t5_err_rdata got=%h exp=0000", {rdata0, rdata1}); end
        do_reset;
        checks++; if ({error0, error1} !== 2'b00) begin failures++; $display("FAIL t5_reset_clears got=%b exp=00", {error0, error1}); end
    endtask

    // Flags readback after expiry, then reset in the middle of a run
    task automatic test_sel_and_reset;
        do_reset;
        issue(OP_LDP, 8'd0);
        issue(OP_LDC, 8'd0);
        issue(OP_START, 8'd0);
        step(1);
        issue(OP_SEL, 8'd2);
        step(1);
        checks++; if ({rdata0, rdata1} !== 16'h0101) begin failures++; $display("FAIL t6_sel_flags got=%h exp=0101", {rdata0, rdata1}); end
        issue(OP_SEL, 8'd0);
        issue(OP_LDC, 8'd9);
        issue(OP_START, 8'd0);
        step(2);
        checks++; if ({rdata0, rdata1} !== {8'd8, 8'd8}) begin failures++; $display("FAIL t6_running got=%h exp=0808", {rdata0, rdata1}); end
        checks++; if ({expired0, expired1} !== 2'b11) begin failures++; $display("FAIL t6_sticky_expired got=%b exp=11", {expired0, expired1}); end
        reset = 1'b1;
        step(1);
        checks++; if ({rdata0, rdata1, expired0, expired1, error0, error1} !== 20'h0) begin failures++; $display("FAIL t6_mid_run_reset got=%h exp=0", {rdata0, rdata1, expired0, expired1, error0, error1}); end
        reset = 1'b0;
        step(4);
        checks++; if ({rdata0, rdata1, expired0, expired1} !== 18'h0) begin failures++; $display("FAIL t6_after_reset got=%h exp=0", {rdata0, rdata1, expired0, expired1}); end
    endtask

    initial begin
        reset   = 1'b1;
        cmd     = '0;
        cmd_wen = 1'b0;
        test_reset;
        test_single_shot;
        test_prescale;
        test_reload;
        test_stop;
        test_error;
        test_sel_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
